// File: rtl/ps_seizure_detector.sv
// ps_seizure_detector
//
// Decision stage behind the power-spectrum feature datapath. Each valid
// feature window is compared against a programmable signed threshold.
// After trig_count consecutive above-threshold windows a debounced alarm is
// raised. It is released after release_count consecutive below-threshold
// windows. A refractory holdoff of holdoff_windows valid windows must then
// pass before the detector can arm again.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   en          active-low enable; when high, all state holds and
//               din_valid / thr_wr are ignored
//   din         signed PS feature
//   din_valid   one-cycle strobe qualifying din
//   thr         signed threshold value
//   thr_wr      loads thr into the threshold register
//   alarm       registered, debounced detection flag
//   alarm_rise  one-cycle pulse on the first cycle alarm is high
//   event_cnt   number of alarms raised since reset, saturating
//   state_dbg   current FSM state encoding

module ps_seizure_detector #(
    parameter int input_width     = 40,
    parameter int count_width     = 8,
    parameter int trig_count      = 3,
    parameter int release_count   = 2,
    parameter int holdoff_windows = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [input_width-1:0] din,
    input  logic                          din_valid,
    input  logic signed [input_width-1:0] thr,
    input  logic                          thr_wr,
    output logic                          alarm,
    output logic                          alarm_rise,
    output logic        [count_width-1:0] event_cnt,
    output logic                    [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        ALARM   = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    // The reset threshold is the most positive signed value. Because the
    // compare is strict, nothing can trigger until a real threshold is loaded.
    localparam logic signed [input_width-1:0] THR_RESET = {1'b0, {(input_width-1){1'b1}}};

    localparam logic [count_width-1:0] TRIG_C  = count_width'(trig_count);
    localparam logic [count_width-1:0] REL_C   = count_width'(release_count);
    localparam logic [count_width-1:0] HOLD_C  = count_width'(holdoff_windows);
    localparam logic [count_width-1:0] EVT_MAX = '1;

    state_t                          state;
    logic        [count_width-1:0]   cnt;
    logic        [count_width-1:0]   rcnt;
    logic        [count_width-1:0]   hcnt;
    logic signed [input_width-1:0]   thr_reg;

    logic                            step;
    logic                            above;
    logic        [count_width-1:0]   cnt_inc;
    logic        [count_width-1:0]   rcnt_inc;
    logic        [count_width-1:0]   hcnt_inc;

    // Only a qualified window while enabled advances anything. The compare
    // uses the registered threshold, so a same-cycle thr_wr only affects
    // later windows.
    assign step     = ~en & din_valid;
    assign above    = din > thr_reg;
    assign cnt_inc  = cnt + 1'b1;
    assign rcnt_inc = rcnt + 1'b1;
    assign hcnt_inc = hcnt + 1'b1;

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rcnt       <= '0;
            hcnt       <= '0;
            thr_reg    <= THR_RESET;
            alarm      <= 1'b0;
            alarm_rise <= 1'b0;
            event_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below reads the pre-edge values of state and counters.
            alarm_rise <= 1'b0;

            if (!en && thr_wr) begin
                thr_reg <= thr;
            end

            if (step) begin
                case (state)
                    IDLE: begin
                        if (above) begin
                            if (TRIG_C == 1) begin
                                cnt        <= '0;
                                state      <= ALARM;
                                alarm      <= 1'b1;
                                alarm_rise <= 1'b1;
                                if (event_cnt != EVT_MAX) event_cnt <= event_cnt + 1'b1;
                            end else begin
                                cnt   <= 1;
                                state <= PEND;
                            end
                        end
                    end

                    PEND: begin
                        if (above) begin
                            if (cnt_inc == TRIG_C) begin
                                cnt        <= '0;
                                state      <= ALARM;
                                alarm      <= 1'b1;
                                alarm_rise <= 1'b1;
                                if (event_cnt != EVT_MAX) event_cnt <= event_cnt + 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end

                    ALARM: begin
                        if (above) begin
                            rcnt <= '0;
                        end else if (rcnt_inc == REL_C) begin
                            rcnt  <= '0;
                            alarm <= 1'b0;
                            state <= (HOLD_C == 0) ? IDLE : HOLDOFF;
                        end else begin
                            rcnt <= rcnt_inc;
                        end
                    end

                    HOLDOFF: begin
                        // Window value is irrelevant here; the window that
                        // finishes the holdoff is not evaluated for triggering.
                        if (hcnt_inc == HOLD_C) begin
                            hcnt  <= '0;
                            state <= IDLE;
                        end else begin
                            hcnt <= hcnt_inc;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps_seizure_detector.sv
// Directed testbench for ps_seizure_detector with default parameters
// (trig_count=3, release_count=2, holdoff_windows=4).

module tb_ps_seizure_detector;

    logic               clk;
    logic               rst;
    logic               en;
    logic signed [39:0] din;
    logic               din_valid;
    logic signed [39:0] thr;
    logic               thr_wr;
    logic               alarm;
    logic               alarm_rise;
    logic         [7:0] event_cnt;
    logic         [1:0] state_dbg;

    int total;
    int bad;

    ps_seizure_detector dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .thr        (thr),
        .thr_wr     (thr_wr),
        .alarm      (alarm),
        .alarm_rise (alarm_rise),
        .event_cnt  (event_cnt),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One valid window; returns 1 time unit after the sampling edge.
    task automatic window(input logic signed [39:0] v);
        din       = v;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic load_thr(input logic signed [39:0] v);
        thr    = v;
        thr_wr = 1'b1;
        @(posedge clk);
        #1;
        thr_wr = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL reset_alarm got=%0b exp=0", alarm); end
        total++; if (alarm_rise !== 1'b0) begin bad++; $display("FAIL reset_rise got=%0b exp=0", alarm_rise); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        total++; if (event_cnt !== 8'd0) begin bad++; $display("FAIL reset_evt got=%0d exp=0", event_cnt); end
    endtask

    task automatic test_reset_threshold();
        // Equal to the reset threshold: strict compare keeps it below.
        window(40'sh7F_FFFF_FFFF);
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL rthr_state got=%0d exp=0", state_dbg); end
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL rthr_alarm got=%0b exp=0", alarm); end
    endtask

    task automatic test_trigger();
        load_thr(1000);
        window(1001);
        total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL trig_w1_state got=%0d exp=1", state_dbg); end
        window(1001);
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL trig_w2_alarm got=%0b exp=0", alarm); end
        window(1001);
        total++; if (alarm !== 1'b1) begin bad++; $display("FAIL trig_alarm got=%0b exp=1", alarm); end
        total++; if (alarm_rise !== 1'b1) begin bad++; $display("FAIL trig_rise got=%0b exp=1", alarm_rise); end
        total++; if (event_cnt !== 8'd1) begin bad++; $display("FAIL trig_evt got=%0d exp=1", event_cnt); end
        total++; if (state_dbg !== 2'd2) begin bad++; $display("FAIL trig_state got=%0d exp=2", state_dbg); end
        @(posedge clk); #1;
        total++; if (alarm_rise !== 1'b0) begin bad++; $display("FAIL trig_rise_end got=%0b exp=0", alarm_rise); end
        total++; if (alarm !== 1'b1) begin bad++; $display("FAIL trig_hold got=%0b exp=1", alarm); end
    endtask

    task automatic test_release_holdoff();
        window(500);
        total++; if (alarm !== 1'b1) begin bad++; $display("FAIL rel_w1 got=%0b exp=1", alarm); end
        window(2000);
        window(500);
        total++; if (alarm !== 1'b1) begin bad++; $display("FAIL rel_w3 got=%0b exp=1", alarm); end
        window(500);
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL rel_w4 got=%0b exp=0", alarm); end
        total++; if (state_dbg !== 2'd3) begin bad++; $display("FAIL rel_holdoff got=%0d exp=3", state_dbg); end
        for (int i = 0; i < 3; i++) begin
            window(5000);
            total++; if (state_dbg !== 2'd3) begin bad++; $display("FAIL hold_w%0d got=%0d exp=3", i + 1, state_dbg); end
        end
        window(5000);
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL hold_done got=%0d exp=0", state_dbg); end
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL hold_alarm got=%0b exp=0", alarm); end
        window(5000);
        window(5000);
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL rearm_early got=%0b exp=0", alarm); end
        window(5000);
        total++; if (alarm !== 1'b1) begin bad++; $display("FAIL rearm got=%0b exp=1", alarm); end
        total++; if (event_cnt !== 8'd2) begin bad++; $display("FAIL rearm_evt got=%0d exp=2", event_cnt); end
    endtask

    // From ALARM with thr=1000: two below windows, then four holdoff windows.
    task automatic release_to_idle();
        for (int i = 0; i < 6; i++) window(0);
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL to_idle got=%0d exp=0", state_dbg); end
    endtask

    task automatic test_pend_drop();
        window(1500);
        window(1500);
        window(999);
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL drop_state got=%0d exp=0", state_dbg); end
        window(1500);
        window(1500);
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL drop_w5 got=%0b exp=0", alarm); end
        window(1500);
        total++; if (alarm !== 1'b1) begin bad++; $display("FAIL drop_w6 got=%0b exp=1", alarm); end
        total++; if (event_cnt !== 8'd3) begin bad++; $display("FAIL drop_evt got=%0d exp=3", event_cnt); end
    endtask

    task automatic test_thr_same_cycle();
        load_thr(0);
        thr       = -50;
        thr_wr    = 1'b1;
        din       = -10;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        thr_wr    = 1'b0;
        din_valid = 1'b0;
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL same_old_thr got=%0d exp=0", state_dbg); end
        window(-10);
        total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL same_new_thr got=%0d exp=1", state_dbg); end
        window(-10);
        window(-10);
        total++; if (alarm !== 1'b1) begin bad++; $display("FAIL same_alarm got=%0b exp=1", alarm); end
        total++; if (event_cnt !== 8'd4) begin bad++; $display("FAIL same_evt got=%0d exp=4", event_cnt); end
    endtask

    task automatic test_async_reset_and_en();
        // Between edges: now at posedge+1, assert at posedge+3.
        #2 rst = 1'b1;
        #1;
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL arst_alarm got=%0b exp=0", alarm); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL arst_state got=%0d exp=0", state_dbg); end
        total++; if (event_cnt !== 8'd0) begin bad++; $display("FAIL arst_evt got=%0d exp=0", event_cnt); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        load_thr(1000);
        en = 1'b1;
        // thr_wr must be ignored while disabled.
        load_thr(-1000);
        for (int i = 0; i < 5; i++) window(5000);
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL en_state got=%0d exp=0", state_dbg); end
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL en_alarm got=%0b exp=0", alarm); end
        en = 1'b0;
        window(500);
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL en_thr_kept got=%0d exp=0", state_dbg); end
        window(5000);
        total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL en_resume got=%0d exp=1", state_dbg); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        en        = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        thr       = '0;
        thr_wr    = 1'b0;
        #12;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset_threshold();
        test_trigger();
        test_release_holdoff();
        release_to_idle();
        test_pend_drop();
        release_to_idle();
        test_thr_same_cycle();
        test_async_reset_and_en();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
